spike_convergence_monitor: RTL and testbench

SPIKE_CONVERGENCE_MONITOR -- requirements
Module: spike_convergence_monitor

---
 rtl/spike_convergence_monitor_pkg.sv | 22 ++
 rtl/spike_convergence_monitor_if.sv | 36 +++
 rtl/spike_popcount.sv | 20 ++
 rtl/spike_convergence_monitor.sv | 129 ++++++++++++
 tb/tb_spike_convergence_monitor.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_convergence_monitor_pkg.sv
// Shared definitions for the spike convergence monitor. The Hopfield top level
// imports this package too, for the state encoding and the default parameters.
package spike_convergence_monitor_pkg;

  localparam int DEF_N_NEURONS      = 7;
  localparam int DEF_STABLE_CYCLES  = 8;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Counter widths: the activity count fits in 3 bits while N_NEURONS <= 7.
  // The cycle count fits in 8 bits while TIMEOUT_CYCLES <= 255.
  // The stable-run count fits in 4 bits while STABLE_CYCLES <= 15.
  localparam int ACT_W = 3;
  localparam int CYC_W = 8;
  localparam int STB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/spike_convergence_monitor_if.sv
// Result channel of the convergence monitor.
// Handshake: the producer raises out_valid with all out_* fields stable and
// holds them unchanged until it samples out_valid && out_ready on a rising
// edge. The consumer may drive out_ready at any time, independent of out_valid.
interface spike_convergence_monitor_if
  import spike_convergence_monitor_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS
) ();

  logic                 out_valid;
  logic                 out_ready;
  logic [N_NEURONS-1:0] out_pattern;
  logic [ACT_W-1:0]     out_activity;
  logic [CYC_W-1:0]     out_cycles;
  logic                 out_converged;

  modport master (
    output out_valid,
    input  out_ready,
    output out_pattern,
    output out_activity,
    output out_cycles,
    output out_converged
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_pattern,
    input  out_activity,
    input  out_cycles,
    input  out_converged
  );

endinterface

// File: rtl/spike_popcount.sv
// Counts the set bits of a spike vector. The result is 3 bits wide, so the
// vector must be at most 7 bits wide.
module spike_popcount
  import spike_convergence_monitor_pkg::*;
#(
  parameter int W = DEF_N_NEURONS
) (
  input  logic [W-1:0]     vec,
  output logic [ACT_W-1:0] count
);

  // Add the bits one at a time; the loop unrolls into a small adder chain.
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + {{(ACT_W-1){1'b0}}, vec[i]};
    end
  end

endmodule

// File: rtl/spike_convergence_monitor.sv
// Measures how many cycles a Hopfield spike vector takes to settle. After a
// start pulse, the monitor watches for STABLE_CYCLES consecutive identical
// samples. It gives up after TIMEOUT_CYCLES cycles. The result is then held
// on the out_if channel until the consumer accepts it.
module spike_convergence_monitor
  import spike_convergence_monitor_pkg::*;
#(
  parameter int N_NEURONS      = DEF_N_NEURONS,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_NEURONS-1:0] spikes,
  output logic                 busy,
  output state_t               dbg_state,
  spike_convergence_monitor_if.master out_if
);

  localparam logic [STB_W-1:0] STABLE_TGT  = STB_W'(STABLE_CYCLES);
  localparam logic [CYC_W-1:0] TIMEOUT_TGT = CYC_W'(TIMEOUT_CYCLES);

  state_t               state_q, state_d;
  logic [N_NEURONS-1:0] prev_q, prev_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [STB_W-1:0]     stable_q, stable_d;
  logic [N_NEURONS-1:0] pat_q, pat_d;
  logic [ACT_W-1:0]     act_q, act_d;
  logic [CYC_W-1:0]     cycles_q, cycles_d;
  logic                 conv_q, conv_d;

  logic [CYC_W-1:0]     cyc_inc;
  logic [STB_W-1:0]     stable_inc;
  logic                 same;
  logic                 hit_stable;
  logic                 hit_timeout;
  logic [ACT_W-1:0]     spikes_act;

  spike_popcount #(.W(N_NEURONS)) u_popcount (
    .vec   (spikes),
    .count (spikes_act)
  );

  // Termination conditions, computed from the counts this edge would produce.
  always_comb begin
    cyc_inc     = cyc_q + CYC_W'(1);
    stable_inc  = stable_q + STB_W'(1);
    same        = (spikes == prev_q);
    hit_stable  = same && (stable_inc == STABLE_TGT);
    hit_timeout = (cyc_inc == TIMEOUT_TGT);
  end

  // Next-state and datapath update. Convergence takes priority over timeout.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    cyc_d    = cyc_q;
    stable_d = stable_q;
    pat_d    = pat_q;
    act_d    = act_q;
    cycles_d = cycles_q;
    conv_d   = conv_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          prev_d   = spikes;
          cyc_d    = '0;
          stable_d = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cyc_d = cyc_inc;
        if (same) begin
          stable_d = stable_inc;
        end else begin
          stable_d = '0;
          prev_d   = spikes;
        end
        if (hit_stable || hit_timeout) begin
          pat_d    = spikes;
          act_d    = spikes_act;
          cycles_d = cyc_inc;
          conv_d   = hit_stable;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_if.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any measurement in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prev_q   <= '0;
      cyc_q    <= '0;
      stable_q <= '0;
      pat_q    <= '0;
      act_q    <= '0;
      cycles_q <= '0;
      conv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cyc_q    <= cyc_d;
      stable_q <= stable_d;
      pat_q    <= pat_d;
      act_q    <= act_d;
      cycles_q <= cycles_d;
      conv_q   <= conv_d;
    end
  end

  assign busy                 = (state_q != ST_IDLE);
  assign dbg_state            = state_q;
  assign out_if.out_valid     = (state_q == ST_HOLD);
  assign out_if.out_pattern   = pat_q;
  assign out_if.out_activity  = act_q;
  assign out_if.out_cycles    = cycles_q;
  assign out_if.out_converged = conv_q;

endmodule

// File: tb/tb_spike_convergence_monitor.sv
// Directed bench for spike_convergence_monitor. u_dut uses the default
// parameters. u_dut2 uses STABLE_CYCLES=4 and TIMEOUT_CYCLES=4 and covers
// the case where convergence and timeout land on the same edge.
module tb_spike_convergence_monitor;
  import spike_convergence_monitor_pkg::*;

  localparam int N = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         start2 = 1'b0;
  logic [N-1:0] spikes = '0;
  logic         busy, busy2;
  state_t       dbg_state, dbg_state2;

  spike_convergence_monitor_if #(.N_NEURONS(N)) out_if ();
  spike_convergence_monitor_if #(.N_NEURONS(N)) out_if2 ();

  spike_convergence_monitor #(.N_NEURONS(N)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .spikes    (spikes),
    .busy      (busy),
    .dbg_state (dbg_state),
    .out_if    (out_if.master)
  );

  spike_convergence_monitor #(.N_NEURONS(N), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(4)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .spikes    (spikes),
    .busy      (busy2),
    .dbg_state (dbg_state2),
    .out_if    (out_if2.master)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on the selected DUT; the edge that samples it is edge 0.
  task automatic pulse_start(input bit which, input logic [N-1:0] s);
    spikes = s;
    if (which) start2 = 1'b1; else start = 1'b1;
    tick();
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  // Hold spikes constant; count edges until out_valid (bounded).
  task automatic wait_valid(input bit which, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(which ? out_if2.out_valid : out_if.out_valid) && n < 300);
  endtask

  // Alternate 01/02 each edge (edge k sees 02 when k is odd); bounded.
  task automatic wait_valid_toggle(input bit which, output int n);
    n = 0;
    do begin
      n++;
      spikes = (n % 2 == 1) ? 7'h02 : 7'h01;
      tick();
    end while (!(which ? out_if2.out_valid : out_if.out_valid) && n < 300);
  endtask

  task automatic check_result(input string tag, input int n, input logic [N-1:0] pat,
                              input logic [2:0] act, input logic [7:0] cyc, input logic conv);
    chk({tag, "_latency"},   n,                    cyc);
    chk({tag, "_valid"},     out_if.out_valid,     1'b1);
    chk({tag, "_pattern"},   out_if.out_pattern,   pat);
    chk({tag, "_activity"},  out_if.out_activity,  act);
    chk({tag, "_cycles"},    out_if.out_cycles,    cyc);
    chk({tag, "_converged"}, out_if.out_converged, conv);
    chk({tag, "_busy"},      busy,                 1'b1);
    chk({tag, "_state"},     dbg_state,            ST_HOLD);
  endtask

  task automatic check_result2(input string tag, input int n, input logic [N-1:0] pat,
                               input logic [2:0] act, input logic [7:0] cyc, input logic conv);
    chk({tag, "_latency"},   n,                     cyc);
    chk({tag, "_pattern"},   out_if2.out_pattern,   pat);
    chk({tag, "_activity"},  out_if2.out_activity,  act);
    chk({tag, "_cycles"},    out_if2.out_cycles,    cyc);
    chk({tag, "_converged"}, out_if2.out_converged, conv);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"},     out_if.out_valid,     1'b0);
    chk({tag, "_pattern"},   out_if.out_pattern,   '0);
    chk({tag, "_activity"},  out_if.out_activity,  '0);
    chk({tag, "_cycles"},    out_if.out_cycles,    '0);
    chk({tag, "_converged"}, out_if.out_converged, 1'b0);
    chk({tag, "_busy"},      busy,                 1'b0);
    chk({tag, "_state"},     dbg_state,            ST_IDLE);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] spikes;
    logic [2:0]   act;
  } vec_t;
  vec_t vecs[6];

  // ---------------- main test ----------------
  initial begin
    int n;
    logic [N-1:0] exp_pat;
    vecs[0] = '{7'h2A, 3'd3};
    vecs[1] = '{7'h00, 3'd0};
    vecs[2] = '{7'h7F, 3'd7};
    vecs[3] = '{7'h01, 3'd1};
    vecs[4] = '{7'h55, 3'd4};
    vecs[5] = '{7'h40, 3'd1};

    out_if.out_ready  = 1'b1;
    out_if2.out_ready = 1'b1;

    // Reset state.
    #12;
    check_all_zero("reset");
    chk("reset_busy2", busy2, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();

    // Constant spike vectors: converge after 8 edges, then handshake with ready=1.
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].spikes);
      pulse_start(1'b0, vecs[i].spikes);
      wait_valid(1'b0, n);
      exp_pat = exp_q.pop_front();
      check_result($sformatf("const%0d", i), n, exp_pat, vecs[i].act, 8'd8, 1'b1);
      tick();
      chk($sformatf("const%0d_release_valid", i), out_if.out_valid, 1'b0);
      chk($sformatf("const%0d_release_busy", i), busy, 1'b0);
    end

    // Spikes toggling every edge never settle: timeout at 255.
    pulse_start(1'b0, 7'h01);
    wait_valid_toggle(1'b0, n);
    check_result("toggle", n, 7'h02, 3'd1, 8'd255, 1'b0);
    tick();

    // Change at edge 5 restarts the stable run: converges at edge 13.
    pulse_start(1'b0, 7'h2A);
    for (int k = 1; k <= 4; k++) tick();
    spikes = 7'h7F;
    wait_valid(1'b0, n);
    check_result("late_change", n + 4, 7'h7F, 3'd7, 8'd13, 1'b1);
    tick();

    // Result pending with ready low: start and spikes must not disturb it.
    out_if.out_ready = 1'b0;
    pulse_start(1'b0, 7'h33);
    wait_valid(1'b0, n);
    check_result("hold", n, 7'h33, 3'd4, 8'd8, 1'b1);
    for (int c = 0; c < 20; c++) begin
      start  = (c == 5);
      spikes = 7'($urandom_range(0, 127));
      tick();
      chk($sformatf("hold_stable%0d", c),
          {busy, out_if.out_valid, out_if.out_pattern, out_if.out_activity,
           out_if.out_cycles, out_if.out_converged},
          {1'b1, 1'b1, 7'h33, 3'd4, 8'd8, 1'b1});
    end
    // Start on the handshake edge is dropped, not queued.
    start = 1'b1;
    out_if.out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("hold_release_valid", out_if.out_valid, 1'b0);
    chk("hold_release_state", dbg_state, ST_IDLE);
    spikes = 7'h0F;
    tick();
    spikes = 7'h70;
    tick();
    chk("idle_no_queue_busy", busy, 1'b0);
    chk("idle_pattern_kept", out_if.out_pattern, 7'h33);

    // Reset in the middle of SETTLE clears everything at once.
    pulse_start(1'b0, 7'h2A);
    for (int k = 1; k <= 4; k++) tick();
    chk("mid_settle_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    #10;
    rst_n = 1'b1;
    tick();
    pulse_start(1'b0, 7'h2A);
    wait_valid(1'b0, n);
    check_result("after_reset", n, 7'h2A, 3'd3, 8'd8, 1'b1);
    tick();

    // STABLE_CYCLES == TIMEOUT_CYCLES == 4: convergence wins on edge 4.
    pulse_start(1'b1, 7'h15);
    wait_valid(1'b1, n);
    check_result2("tie", n, 7'h15, 3'd3, 8'd4, 1'b1);
    chk("tie_dut1_idle", busy, 1'b0);
    tick();
    chk("tie_release", out_if2.out_valid, 1'b0);

    // Same configuration, never stable: timeout on edge 4.
    pulse_start(1'b1, 7'h01);
    wait_valid_toggle(1'b1, n);
    check_result2("short_timeout", n, 7'h01, 3'd1, 8'd4, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
